// File: rtl/key_matrix_scanner.sv
// key_matrix_scanner: scans an 8x8 active-low key matrix and reports a debounced 64-bit key map
// Ports:
//   i_clk       system clock
//   i_reset     synchronous active-low reset
//   i_rows      row sense lines, active-low, asynchronous to i_clk
//   o_cols      column drive, active-low one-hot, 8'hFF when no column is driven
//   o_keys      debounced key map, bit 8*c+r set when key (c,r) is pressed
//   o_valid     one-cycle pulse when o_keys takes a new value
//   o_scan_done one-cycle pulse at the end of every complete scan
module key_matrix_scanner #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic [7:0]  i_rows,
  output logic [7:0]  o_cols,
  output logic [63:0] o_keys,
  output logic        o_valid,
  output logic        o_scan_done
);
  localparam int CW = $clog2(SETTLE_CYCLES);
  localparam int SW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(SETTLE_CYCLES - 1);
  localparam logic [SW-1:0] DB_MAX = SW'(DEBOUNCE_SCANS);
  localparam logic [0:0] DRIVE = 1'b0;
  localparam logic [0:0] COMPARE = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [2:0]    col_q, col_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [7:0]    cols_q, cols_d;
  logic [63:0]   scratch_q, scratch_d;
  logic [63:0]   prev_q, prev_d;
  logic [SW-1:0] stable_q, stable_d;
  logic [63:0]   keys_q, keys_d;
  logic          valid_q, valid_d;
  logic          done_q, done_d;
  logic [7:0]    sync1_q, sync2_q;
  logic [SW-1:0] new_cnt;
  logic          accept;
  assign new_cnt = (scratch_q == prev_q) ? ((stable_q == DB_MAX) ? DB_MAX : stable_q + 1'b1) : SW'(1);
  assign accept  = (new_cnt == DB_MAX) && (scratch_q != keys_q);
  always_comb begin
    state_d   = state_q;
    col_d     = col_q;
    cnt_d     = cnt_q;
    cols_d    = cols_q;
    scratch_d = scratch_q;
    prev_d    = prev_q;
    stable_d  = stable_q;
    keys_d    = keys_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    if (state_q == DRIVE) begin
      // Columns are only idle in DRIVE right after reset: start driving before counting settle time.
      if (cols_q == 8'hFF) cols_d = ~(8'b1 << col_q);
      else if (cnt_q != CNT_LAST) cnt_d = cnt_q + 1'b1;
      else begin
        scratch_d[8*col_q +: 8] = ~sync2_q;
        cnt_d   = '0;
        col_d   = col_q + 3'd1;
        state_d = (col_q == 3'd7) ? COMPARE : DRIVE;
        cols_d  = (col_q == 3'd7) ? 8'hFF : ~(8'b1 << col_d);
      end
    end else begin
      prev_d   = scratch_q;
      stable_d = new_cnt;
      keys_d   = accept ? scratch_q : keys_q;
      valid_d  = accept;
      done_d   = 1'b1;
      col_d    = 3'd0;
      cnt_d    = '0;
      cols_d   = 8'hFE;
      state_d  = DRIVE;
    end
  end
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q   <= DRIVE;
      col_q     <= 3'd0;
      cnt_q     <= '0;
      cols_q    <= 8'hFF;
      scratch_q <= '0;
      prev_q    <= '0;
      stable_q  <= '0;
      keys_q    <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      sync1_q   <= 8'hFF;
      sync2_q   <= 8'hFF;
    end else begin
      state_q   <= state_d;
      col_q     <= col_d;
      cnt_q     <= cnt_d;
      cols_q    <= cols_d;
      scratch_q <= scratch_d;
      prev_q    <= prev_d;
      stable_q  <= stable_d;
      keys_q    <= keys_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      sync1_q   <= i_rows;
      sync2_q   <= sync1_q;
    end
  end
  assign o_cols      = cols_q;
  assign o_keys      = keys_q;
  assign o_valid     = valid_q;
  assign o_scan_done = done_q;
endmodule
